// File: rtl/fifo_rd_sched_if.sv
// Signal bundle between the read scheduler, the FIFO read port and the downstream stream.
interface fifo_rd_sched_if #(
  parameter int DATA_WIDTH = 36
);
  logic                  fifo_rd_en_o;
  logic [DATA_WIDTH-1:0] fifo_rd_data_i;
  logic                  fifo_empty_i;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_valid_o;
  logic                  m_ready_i;

  modport master (
    output fifo_rd_en_o, m_data_o, m_valid_o,
    input  fifo_rd_data_i, fifo_empty_i, m_ready_i
  );

  modport slave (
    input  fifo_rd_en_o, m_data_o, m_valid_o,
    output fifo_rd_data_i, fifo_empty_i, m_ready_i
  );
endinterface

// File: rtl/fifo_rd_sched.sv
// Credit-based read scheduler: turns a fixed-latency FIFO read port into a valid/ready stream
// with burst/continuous sequencing and a small skid buffer absorbing the read latency.
module fifo_rd_sched #(
  parameter int    DATA_WIDTH = 36,
  parameter string REGMODE    = "reg",
  parameter int    SKID_DEPTH = 4,
  parameter int    CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [CNT_WIDTH-1:0] burst_len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] rd_count_o,
  fifo_rd_sched_if.master      bus
);
  localparam int          LAT     = (REGMODE == "noreg") ? 1 : 2;
  localparam int          PTR_W   = $clog2(SKID_DEPTH);
  localparam int          OCC_W   = $clog2(SKID_DEPTH + 1);
  localparam int          FLT_W   = $clog2(LAT + 1);
  localparam logic [31:0] DEPTH_U = SKID_DEPTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   len_q, len_d;
  logic [CNT_WIDTH-1:0]   issued_q, issued_d;
  logic [CNT_WIDTH-1:0]   rd_count_q, rd_count_d;
  logic [LAT-1:0]         vld_q;
  logic [FLT_W-1:0]       inflight;
  logic [DATA_WIDTH-1:0]  mem_q [SKID_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]       occ_q;
  logic                   rd_en, push, pop, credit_ok, len_ok;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + FLT_W'(vld_q[i]);
    end
  end

  // Credit uses occupancy before this cycle's pop so rd_en never depends on m_ready_i.
  assign credit_ok = (32'(inflight) + 32'(occ_q)) < DEPTH_U;
  assign len_ok    = (len_q == '0) || (issued_q < len_q);
  assign rd_en     = (state_q == S_RUN) && !bus.fifo_empty_i && credit_ok && len_ok;
  assign push      = vld_q[LAT-1];
  assign pop       = bus.m_valid_o && bus.m_ready_i;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    rd_count_d = rd_count_q + CNT_WIDTH'(pop);
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_RUN;
          len_d      = burst_len_i;
          issued_d   = '0;
          rd_count_d = '0;
        end
      end
      S_RUN: begin
        issued_d = issued_q + CNT_WIDTH'(rd_en);
        if (stop_i || ((len_q != '0) && (issued_d == len_q))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((inflight == '0) && (occ_q == '0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      rd_count_q <= '0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      rd_count_q <= rd_count_d;
      vld_q[0]   <= rd_en;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Skid buffer is a circular queue; depth need not be a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.fifo_rd_data_i;
        wr_ptr_q        <= (wr_ptr_q == PTR_W'(SKID_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(SKID_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (rst_i) !(push && (occ_q == OCC_W'(SKID_DEPTH))))
    else $error("fifo_rd_sched: skid push while full");
`endif

  assign bus.fifo_rd_en_o = rd_en;
  assign bus.m_valid_o    = (occ_q != '0);
  assign bus.m_data_o     = mem_q[rd_ptr_q];
  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = (state_q == S_DONE);
  assign rd_count_o       = rd_count_q;
endmodule
